// File: rtl/player_ctrl_pkg.sv
// Shared screen geometry, motion state type and the saturating horizontal step
// used by the SkyHop player controller.
package player_ctrl_pkg;

   localparam int SCREEN_W = 800;
   localparam int SCREEN_H = 600;
   localparam int PLAYER_W = 80;
   localparam int PLAYER_H = 80;

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_FALL   = 2'd2
   } motion_state_t;

   // Widened to 12 signed bits so a step left from near zero cannot wrap.
   function automatic logic [9:0] step_x(
      input logic [9:0]         x,
      input logic               left,
      input logic               right,
      input logic signed [11:0] step,
      input logic signed [11:0] x_min,
      input logic signed [11:0] x_max
   );
      logic signed [11:0] xs;
      logic signed [11:0] res;
      xs  = signed'({2'b00, x});
      res = xs;
      if (left && !right) begin
         res = xs - step;
         if (res < x_min) res = x_min;
      end else if (right && !left) begin
         res = xs + step;
         if (res > x_max) res = x_max;
      end
      return res[9:0];
   endfunction

endpackage

// File: rtl/player_ctrl_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse two edges after the input rises.
module edge_detect (
   input  logic pclk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic din_q;
   logic din_qq;

   always_ff @(posedge pclk) begin
      if (rst) begin
         din_q  <= 1'b0;
         din_qq <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         din_q  <= din;
         din_qq <= din_q;
         pulse  <= din_q & ~din_qq;
      end
   end

endmodule

// File: rtl/player_ctrl.sv
// SkyHop player motion: per-frame horizontal saturation and a jump/gravity FSM
// driving the sprite position into the rectangle-drawing stage.
//
// state     | meaning
// ----------+---------------------------------------------
// ST_GROUND | standing at Y_GROUND, vel = 0, jump allowed
// ST_RISE   | airborne, vel < 0 (moving up)
// ST_FALL   | airborne, vel >= 0 (falling until landing)
module player_ctrl
   import player_ctrl_pkg::*;
#(
   parameter int X_INIT   = (SCREEN_W - PLAYER_W) / 2,
   parameter int X_MIN    = 0,
   parameter int X_MAX    = SCREEN_W - PLAYER_W,
   parameter int Y_GROUND = SCREEN_H - PLAYER_H,
   parameter int X_STEP   = 4,
   parameter int JUMP_V   = 12,
   parameter int GRAVITY  = 1,
   parameter int V_MAX    = 15
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       vsync_in,
   input  logic       game_en,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_jump,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic       on_ground,
   output logic       sprite_en
);

   localparam logic signed [11:0] XMIN_S   = 12'(X_MIN);
   localparam logic signed [11:0] XMAX_S   = 12'(X_MAX);
   localparam logic signed [11:0] XSTEP_S  = 12'(X_STEP);
   localparam logic signed [11:0] YG_S     = 12'(Y_GROUND);
   localparam logic signed [11:0] JV_S     = 12'(JUMP_V);
   localparam logic signed [11:0] GR_S     = 12'(GRAVITY);
   localparam logic signed [11:0] VMAX_S   = 12'(V_MAX);
   localparam logic signed [11:0] LAUNCH_V = GR_S - JV_S;

   motion_state_t      state;
   logic signed [6:0]  vel;
   logic               tick;
   logic               jump_edge;
   logic               jump_latch;
   logic signed [11:0] vel_ext;
   logic signed [11:0] vel_next;
   logic signed [11:0] ny;

   edge_detect u_vsync_edge (
      .pclk  (pclk),
      .rst   (rst),
      .din   (vsync_in),
      .pulse (tick)
   );

   edge_detect u_jump_edge (
      .pclk  (pclk),
      .rst   (rst),
      .din   (btn_jump),
      .pulse (jump_edge)
   );

   // A press coinciding with the tick survives the clear and applies next frame.
   always_ff @(posedge pclk) begin
      if (rst)            jump_latch <= 1'b0;
      else if (jump_edge) jump_latch <= 1'b1;
      else if (tick)      jump_latch <= 1'b0;
   end

   always_ff @(posedge pclk) begin
      if (rst) sprite_en <= 1'b0;
      else     sprite_en <= game_en;
   end

   always_comb begin
      vel_ext  = {{5{vel[6]}}, vel};
      vel_next = vel_ext + GR_S;
      if (vel_next > VMAX_S) vel_next = VMAX_S;
      if (state == ST_GROUND) ny = YG_S - JV_S;
      else                    ny = signed'({2'b00, ypos}) + vel_ext;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state     <= ST_GROUND;
         xpos      <= 10'(X_INIT);
         ypos      <= YG_S[9:0];
         vel       <= '0;
         on_ground <= 1'b1;
      end else if (tick && game_en) begin
         xpos <= step_x(xpos, btn_left, btn_right, XSTEP_S, XMIN_S, XMAX_S);
         case (state)
            ST_GROUND: begin
               if (jump_latch) begin
                  on_ground <= 1'b0;
                  if (ny < 12'sd0) begin
                     ypos  <= '0;
                     vel   <= '0;
                     state <= ST_FALL;
                  end else begin
                     ypos  <= ny[9:0];
                     vel   <= LAUNCH_V[6:0];
                     state <= (LAUNCH_V < 12'sd0) ? ST_RISE : ST_FALL;
                  end
               end else begin
                  ypos <= YG_S[9:0];
                  vel  <= '0;
               end
            end
            default: begin
               if (ny >= YG_S) begin
                  ypos      <= YG_S[9:0];
                  vel       <= '0;
                  state     <= ST_GROUND;
                  on_ground <= 1'b1;
               end else if (ny < 12'sd0) begin
                  ypos  <= '0;
                  vel   <= '0;
                  state <= ST_FALL;
               end else begin
                  ypos <= ny[9:0];
                  vel  <= vel_next[6:0];
                  if (vel_next >= 12'sd0) state <= ST_FALL;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: a frame-level motion model checked every cycle against a
// default instance and a low-ceiling instance, plus hand-computed arc/saturation points.
module tb_player_ctrl;

   typedef struct {
      int x_init, x_min, x_max, y_ground, x_step, jump_v, gravity, v_max;
   } prm_t;

   typedef struct {
      int x;
      int y;
      int v;
      bit air;
   } mdl_t;

   logic       pclk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync_in = 1'b0;
   logic       game_en = 1'b1;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       btn_jump = 1'b0;
   logic [9:0] xa, ya, xb, yb;
   logic       ga, sa, gb, sb;

   int checks = 0;
   int errors = 0;

   prm_t pa = '{360, 0, 720, 520, 4, 12, 1, 15};
   prm_t pb = '{2, 0, 720, 20, 4, 30, 1, 15};
   mdl_t ma, mb;
   bit   m_sen;
   bit   pending;
   logic [2:0] vs_h, j_h;

   always #5 pclk = ~pclk;

   player_ctrl dut_a (
      .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .game_en(game_en),
      .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
      .xpos(xa), .ypos(ya), .on_ground(ga), .sprite_en(sa)
   );

   player_ctrl #(.X_INIT(2), .Y_GROUND(20), .JUMP_V(30)) dut_b (
      .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .game_en(game_en),
      .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
      .xpos(xb), .ypos(yb), .on_ground(gb), .sprite_en(sb)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic mdl_t advance(mdl_t m, prm_t p, bit l, bit r, bit jmp);
      int ny;
      if (l && !r)      m.x = (m.x - p.x_step < p.x_min) ? p.x_min : m.x - p.x_step;
      else if (r && !l) m.x = (m.x + p.x_step > p.x_max) ? p.x_max : m.x + p.x_step;
      if (!m.air) begin
         if (jmp) begin
            m.air = 1;
            ny = p.y_ground - p.jump_v;
            if (ny < 0) begin m.y = 0; m.v = 0; end
            else begin m.y = ny; m.v = p.gravity - p.jump_v; end
         end
      end else begin
         ny = m.y + m.v;
         if (ny >= p.y_ground) begin m.y = p.y_ground; m.v = 0; m.air = 0; end
         else if (ny < 0)      begin m.y = 0; m.v = 0; end
         else begin
            m.y = ny;
            m.v = (m.v + p.gravity > p.v_max) ? p.v_max : m.v + p.gravity;
         end
      end
      return m;
   endfunction

   // Tick reaches the FSM two edges after vsync is first sampled high; same for jump.
   always @(posedge pclk) begin
      bit tk, je;
      if (rst) begin
         ma = '{x: pa.x_init, y: pa.y_ground, v: 0, air: 0};
         mb = '{x: pb.x_init, y: pb.y_ground, v: 0, air: 0};
         m_sen = 0;
         pending = 0;
         vs_h = '0;
         j_h = '0;
      end else begin
         tk = vs_h[1] & ~vs_h[2];
         je = j_h[1] & ~j_h[2];
         if (tk) begin
            if (game_en) begin
               ma = advance(ma, pa, btn_left, btn_right, pending);
               mb = advance(mb, pb, btn_left, btn_right, pending);
            end
            pending = 0;
         end
         if (je) pending = 1;
         vs_h = {vs_h[1:0], vsync_in};
         j_h  = {j_h[1:0], btn_jump};
         m_sen = game_en;
      end
      #1;
      chk("a_xpos", int'(xa), ma.x);
      chk("a_ypos", int'(ya), ma.y);
      chk("a_on_ground", int'(ga), int'(!ma.air));
      chk("a_sprite_en", int'(sa), int'(m_sen));
      chk("b_xpos", int'(xb), mb.x);
      chk("b_ypos", int'(yb), mb.y);
      chk("b_on_ground", int'(gb), int'(!mb.air));
      chk("b_sprite_en", int'(sb), int'(m_sen));
   end

   task automatic frame(input bit with_jump = 0);
      @(negedge pclk);
      vsync_in = 1'b1;
      if (with_jump) btn_jump = 1'b1;
      repeat (3) @(negedge pclk);
      vsync_in = 1'b0;
      repeat (3) @(negedge pclk);
   endtask

   task automatic press();
      @(negedge pclk);
      btn_jump = 1'b1;
      @(negedge pclk);
      btn_jump = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge pclk);
      chk("rst_xpos", int'(xa), 360);
      chk("rst_ypos", int'(ya), 520);
      chk("rst_on_ground", int'(ga), 1);
      chk("rst_sprite_en", int'(sa), 0);
      rst = 1'b0;
      frame();
      frame();

      // Full arc from one press; low-ceiling instance clamps at the top.
      press();
      for (int t = 1; t <= 25; t++) begin
         frame();
         case (t)
            1: begin
               chk("arc_t1", int'(ya), 508);
               chk("ceil_t1_y", int'(yb), 0);
               chk("ceil_t1_gnd", int'(gb), 0);
            end
            2: begin
               chk("arc_t2", int'(ya), 497);
               chk("ceil_t2_y", int'(yb), 0);
            end
            3:  chk("ceil_t3_y", int'(yb), 1);
            12: begin
               chk("arc_t12", int'(ya), 442);
               chk("arc_t12_gnd", int'(ga), 0);
            end
            13: chk("arc_t13", int'(ya), 442);
            25: begin
               chk("arc_t25", int'(ya), 520);
               chk("arc_t25_gnd", int'(ga), 1);
            end
            default: ;
         endcase
      end

      // Right saturation: instance b walks 2 -> 718 -> 720.
      btn_right = 1'b1;
      repeat (179) frame();
      chk("right_718", int'(xb), 718);
      frame();
      chk("right_720", int'(xb), 720);
      chk("right_a_sat", int'(xa), 720);
      frame();
      chk("right_hold", int'(xb), 720);
      btn_right = 1'b0;

      // Reset in the middle of a jump.
      press();
      repeat (5) frame();
      @(negedge pclk);
      rst = 1'b1;
      @(negedge pclk);
      chk("midrst_xpos", int'(xa), 360);
      chk("midrst_ypos", int'(ya), 520);
      chk("midrst_on_ground", int'(ga), 1);
      chk("midrst_sprite_en", int'(sa), 0);
      chk("midrst_b_xpos", int'(xb), 2);
      rst = 1'b0;

      // Left saturation from x=2, then both buttons hold.
      btn_left = 1'b1;
      for (int f = 1; f <= 3; f++) begin
         frame();
         chk("left_sat_b", int'(xb), 0);
         chk("left_a", int'(xa), 360 - 4 * f);
      end
      btn_right = 1'b1;
      frame();
      frame();
      chk("both_hold", int'(xa), 348);
      btn_left = 1'b0;
      btn_right = 1'b0;

      // Jump pressed with the tick and held for 40 frames: one jump, one frame late.
      frame(1);
      chk("held_latched_y", int'(ya), 520);
      chk("held_latched_gnd", int'(ga), 1);
      frame();
      chk("held_launch", int'(ya), 508);
      for (int f = 3; f <= 40; f++) begin
         frame();
         if (f == 25) chk("held_t24_gnd", int'(ga), 0);
         if (f == 26) chk("held_land", int'(ga), 1);
      end
      chk("held_no_rejump", int'(ya), 520);
      btn_jump = 1'b0;
      frame();

      // Pause mid-arc.
      press();
      repeat (7) frame();
      chk("pause_t7", int'(ya), 457);
      @(negedge pclk);
      game_en = 1'b0;
      repeat (10) frame();
      chk("pause_hold_y", int'(ya), 457);
      chk("pause_sprite_en", int'(sa), 0);
      game_en = 1'b1;
      frame();
      chk("pause_resume", int'(ya), 452);

      repeat (3) @(negedge pclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
